mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Lets two masters share one port of a dual-port RAM. At most one master is
// granted per cycle. A lone requester always wins. When both masters request,
// a 1-bit round-robin pointer decides the winner. Every grant gets exactly one
// response, delivered one cycle later. A grant to an out-of-range address
// produces an error response and does not touch the RAM.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   mK_req_i                     master K requests an access
//   mK_addr_i                    byte address; bits [1:0] are ignored
//   mK_we_i / mK_be_i            write enable / byte enables
//   mK_wdata_i                   write data
//   mK_gnt_o                     request accepted; combinational from req
//   mK_rvalid_o                  response strobe, one cycle after the grant
//   mK_rdata_o / mK_err_o        response data / error; zero when not valid
//   ram_en_o, ram_we_o,          shared RAM port; held at zero unless an
//   ram_be_o, ram_addr_o,        in-range grant occurs this cycle
//   ram_wdata_o
//   ram_rdata_i                  RAM read data, one cycle after ram_en_o
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req_i,
  input  logic [31:0]           m0_addr_i,
  input  logic                  m0_we_i,
  input  logic [3:0]            m0_be_i,
  input  logic [31:0]           m0_wdata_i,
  output logic                  m0_gnt_o,
  output logic                  m0_rvalid_o,
  output logic [31:0]           m0_rdata_o,
  output logic                  m0_err_o,
  input  logic                  m1_req_i,
  input  logic [31:0]           m1_addr_i,
  input  logic                  m1_we_i,
  input  logic [3:0]            m1_be_i,
  input  logic [31:0]           m1_wdata_i,
  output logic                  m1_gnt_o,
  output logic                  m1_rvalid_o,
  output logic [31:0]           m1_rdata_o,
  output logic                  m1_err_o,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [31:0]           ram_wdata_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  input  logic [31:0]           ram_rdata_i
);

  // Bits at or above this position must be zero for an address to map
  // onto the RAM.
  localparam int HI_LSB = ADDR_WIDTH + 2;

  // Round-robin pointer: 0 means m0 wins a tie, 1 means m1 wins a tie.
  logic ptr_reg;

  // Response pipeline: one entry, captured at each grant.
  logic rsp_valid_reg;
  logic rsp_id_reg;
  logic rsp_read_reg;
  logic rsp_err_reg;

  logic        gnt0;
  logic        gnt1;
  logic        any_gnt;
  logic [31:0] sel_addr;
  logic        sel_we;
  logic [3:0]  sel_be;
  logic [31:0] sel_wdata;
  logic        in_range;
  logic        ram_access;

  // The pointer only matters when both masters request at once.
  // Reset blocks every grant.
  assign gnt0    = !rst && m0_req_i && (!m1_req_i || !ptr_reg);
  assign gnt1    = !rst && m1_req_i && (!m0_req_i ||  ptr_reg);
  assign any_gnt = gnt0 || gnt1;

  assign m0_gnt_o = gnt0;
  assign m1_gnt_o = gnt1;

  always_comb begin
    sel_addr  = m0_addr_i;
    sel_we    = m0_we_i;
    sel_be    = m0_be_i;
    sel_wdata = m0_wdata_i;
    if (gnt1) begin
      sel_addr  = m1_addr_i;
      sel_we    = m1_we_i;
      sel_be    = m1_be_i;
      sel_wdata = m1_wdata_i;
    end
  end

  assign in_range   = (sel_addr >> HI_LSB) == 32'd0;
  assign ram_access = any_gnt && in_range;

  // The RAM port is zero unless an in-range access is actually issued.
  // This keeps the RAM controls quiet during out-of-range grants as well.
  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_be_o    = 4'd0;
    ram_addr_o  = '0;
    ram_wdata_o = 32'd0;
    if (ram_access) begin
      ram_en_o    = 1'b1;
      ram_we_o    = sel_we;
      ram_be_o    = sel_be;
      ram_addr_o  = sel_addr[ADDR_WIDTH+1:2];
      ram_wdata_o = sel_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg       <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= 1'b0;
      rsp_read_reg  <= 1'b0;
      rsp_err_reg   <= 1'b0;
    end else begin
      rsp_valid_reg <= any_gnt;
      if (any_gnt) begin
        rsp_id_reg   <= gnt1;
        rsp_read_reg <= !sel_we;
        rsp_err_reg  <= !in_range;
        // After a grant, the pointer moves to the master that lost.
        ptr_reg      <= gnt0;
      end
    end
  end

  // A response pending while reset is asserted is dropped. The reset edge
  // also clears it, so no rvalid appears after reset is released.
  logic        rsp_fire;
  logic [31:0] rsp_data;

  assign rsp_fire = rsp_valid_reg && !rst;
  assign rsp_data = (rsp_read_reg && !rsp_err_reg) ? ram_rdata_i : 32'd0;

  logic [1:0]  rvalid_vec;
  logic [1:0]  err_vec;
  logic [31:0] rdata_vec [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rsp
      assign rvalid_vec[gi] = rsp_fire && (rsp_id_reg == 1'(gi));
      assign err_vec[gi]    = rvalid_vec[gi] && rsp_err_reg;
      assign rdata_vec[gi]  = rvalid_vec[gi] ? rsp_data : 32'd0;
    end
  endgenerate

  assign m0_rvalid_o = rvalid_vec[0];
  assign m1_rvalid_o = rvalid_vec[1];
  assign m0_err_o    = err_vec[0];
  assign m1_err_o    = err_vec[1];
  assign m0_rdata_o  = rdata_vec[0];
  assign m1_rdata_o  = rdata_vec[1];

endmodule
